// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM encoding and
// the number of input patterns a 3-input circuit has.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int NUM_PATTERNS = 8;
  localparam int IDX_W        = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

endpackage

// File: rtl/truth_table_sweeper_hold_counter.sv
// Free-running hold counter with synchronous clear and a terminal-count flag
// that is high while the count equals TERMINAL.
module hold_counter #(
  parameter int W        = 8,
  parameter int TERMINAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight A/B/C patterns into a 3-input circuit, samples Z at the
// end of each hold window, and compares the captured table to expect_in.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expect_in,
  input  logic       z_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       sample_valid,
  output logic [3:0] mismatch_count,
  output logic       pass,
  output logic [1:0] state_dbg
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       table_q, table_d;
  logic [7:0]       expected_q, expected_d;
  logic [3:0]       mism_q, mism_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic hold_clr;
  logic hold_en;
  logic hold_tc;
  logic sample;

  hold_counter #(
    .W        (8),
    .TERMINAL (HOLD_CYCLES - 1)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (hold_clr),
    .en  (hold_en),
    .tc  (hold_tc)
  );

  // A sample happens on the last cycle of each pattern's hold window.
  assign sample = (state_q == ST_DRIVE) && hold_tc;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    expected_d = expected_q;
    mism_d     = mism_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hold_clr   = 1'b0;
    hold_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          idx_d      = '0;
          table_d    = '0;
          mism_d     = '0;
          pass_d     = 1'b0;
          expected_d = expect_in;
          busy_d     = 1'b1;
          hold_clr   = 1'b1;
        end
      end
      ST_DRIVE: begin
        hold_en = 1'b1;
        if (sample) begin
          table_d[idx_q] = z_in;
          if (z_in != expected_q[idx_q]) begin
            mism_d = mism_q + 4'd1;
          end
          hold_clr = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        pass_d  = (mism_q == 4'd0);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      table_q    <= '0;
      expected_q <= '0;
      mism_q     <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      table_q    <= table_d;
      expected_q <= expected_d;
      mism_q     <= mism_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Pattern outputs are forced to 000 outside DRIVE.
  assign {a_out, b_out, c_out} = busy_q ? idx_q : 3'b000;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign sample_valid   = sample;
  assign mismatch_count = mism_q;
  assign pass           = pass_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with HOLD_CYCLES=4 and 2 instances,
// a behavioural AND3/XOR3 downstream circuit, and a pattern scoreboard.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start2;
  logic [7:0] expect_in;
  logic       use_xor;
  logic       sel;

  logic       a4, b4, c4, busy4, done4, sv4, pass4, z4;
  logic [7:0] table4;
  logic [3:0] mc4;
  logic [1:0] st4;
  logic       a2, b2, c2, busy2, done2, sv2, pass2, z2;
  logic [7:0] table2;
  logic [3:0] mc2;
  logic [1:0] st2;

  logic [2:0] m_abc;
  logic       m_busy, m_done, m_sv, m_pass;
  logic [7:0] m_table;
  logic [3:0] m_mc;
  logic [1:0] m_st;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic circ(input logic [2:0] p);
    return use_xor ? ^p : &p;
  endfunction

  assign z4 = circ({a4, b4, c4});
  assign z2 = circ({a2, b2, c2});

  truth_table_sweeper #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .expect_in(expect_in), .z_in(z4),
    .a_out(a4), .b_out(b4), .c_out(c4), .busy(busy4), .done(done4),
    .table_out(table4), .sample_valid(sv4), .mismatch_count(mc4),
    .pass(pass4), .state_dbg(st4)
  );

  truth_table_sweeper #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .expect_in(expect_in), .z_in(z2),
    .a_out(a2), .b_out(b2), .c_out(c2), .busy(busy2), .done(done2),
    .table_out(table2), .sample_valid(sv2), .mismatch_count(mc2),
    .pass(pass2), .state_dbg(st2)
  );

  always_comb begin
    m_abc   = sel ? {a2, b2, c2} : {a4, b4, c4};
    m_busy  = sel ? busy2 : busy4;
    m_done  = sel ? done2 : done4;
    m_sv    = sel ? sv2 : sv4;
    m_table = sel ? table2 : table4;
    m_mc    = sel ? mc2 : mc4;
    m_pass  = sel ? pass2 : pass4;
    m_st    = sel ? st2 : st4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_idle_zero(input string tag);
    check({tag, "_abc"},   32'(m_abc), 0);
    check({tag, "_busy"},  32'(m_busy), 0);
    check({tag, "_done"},  32'(m_done), 0);
    check({tag, "_sv"},    32'(m_sv), 0);
    check({tag, "_table"}, 32'(m_table), 0);
    check({tag, "_mc"},    32'(m_mc), 0);
    check({tag, "_pass"},  32'(m_pass), 0);
    check({tag, "_state"}, 32'(m_st), 0);
  endtask

  task automatic drive_start(input logic v);
    start4 = sel ? 1'b0 : v;
    start2 = sel ? v : 1'b0;
  endtask

  // Runs one sweep starting at a negedge; ends one cycle after done.
  task automatic run_sweep(input logic s, input int h, input logic xr,
                           input logic [7:0] exp_tbl, input bit poke);
    logic [7:0] t;
    logic [7:0] e;
    int mc, n, last, samples;
    bit got_done;
    sel = s;
    use_xor = xr;
    t = '0;
    for (int i = 0; i < 8; i++) t[i] = circ(3'(i));
    mc = $countones(t ^ exp_tbl);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    expect_in = exp_tbl;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    expect_in = ~exp_tbl;
    n = 1; last = 0; samples = 0; got_done = 0;
    while (n <= 8 * h + 4 && !got_done) begin
      if (poke) drive_start(n == 10);
      if (n <= 8 * h) begin
        check("drive_abc", 32'(m_abc), 32'((n - 1) / h));
        check("drive_busy", 32'(m_busy), 1);
      end
      if (m_sv) begin
        samples++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sample_abc", 32'(m_abc), 32'(e));
        end else begin
          check("sample_extra", 32'(samples), 8);
        end
        if (samples > 1) check("sample_gap", 32'(n - last), 32'(h));
        last = n;
      end
      if (m_done) begin
        got_done = 1;
        check("done_cycle", 32'(n), 32'(8 * h + 1));
        check("done_table", 32'(m_table), 32'(t));
        check("done_mc", 32'(m_mc), 32'(mc));
        check("done_samples", 32'(samples), 8);
        check("done_abc", 32'(m_abc), 0);
        check("done_busy", 32'(m_busy), 0);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    drive_start(1'b0);
    @(negedge clk);
    check("after_pass", 32'(m_pass), 32'(mc == 0));
    check("after_busy", 32'(m_busy), 0);
    check("after_state", 32'(m_st), 0);
    check("after_table", 32'(m_table), 32'(t));
    check("after_done", 32'(m_done), 0);
    exp_q.delete();
  endtask

  initial begin
    int n, dones, d1, d2, b34, b35;
    rst = 1'b1; start4 = 1'b0; start2 = 1'b0; expect_in = 8'h00;
    use_xor = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_all_idle_zero("reset4");
    sel = 1'b1;
    check_all_idle_zero("reset2");
    rst = 1'b0;
    @(negedge clk);

    run_sweep(1'b0, 4, 1'b0, 8'h80, 1'b0);
    run_sweep(1'b0, 4, 1'b1, 8'h96, 1'b1);
    @(negedge clk);
    check("poke_no_restart", 32'(m_busy), 0);
    run_sweep(1'b0, 4, 1'b0, 8'h00, 1'b0);
    run_sweep(1'b1, 2, 1'b0, 8'h80, 1'b0);
    run_sweep(1'b1, 2, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
    run_sweep(1'b0, 4, 1'b1, 8'(~8'h96), 1'b0);

    // Reset in the middle of pattern 3 abandons the sweep.
    sel = 1'b0; use_xor = 1'b0; expect_in = 8'h80;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (n < 14) begin @(negedge clk); n++; end
    check("pre_rst_abc", 32'(m_abc), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_idle_zero("mid_rst");
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_done) dones++;
    end
    check("rst_no_done", 32'(dones), 0);

    // Start held high: back-to-back sweeps one IDLE cycle apart.
    sel = 1'b0; use_xor = 1'b0; expect_in = 8'h80;
    start4 = 1'b1;
    @(negedge clk);
    n = 1; dones = 0; d1 = 0; d2 = 0; b34 = -1; b35 = -1;
    while (n <= 75) begin
      if (n == 34) b34 = int'(m_busy);
      if (n == 35) b35 = int'(m_busy);
      if (m_done) begin
        dones++;
        if (dones == 1) d1 = n;
        if (dones == 2) begin d2 = n; start4 = 1'b0; end
      end
      @(negedge clk);
      n++;
    end
    check("b2b_done1", 32'(d1), 33);
    check("b2b_done2", 32'(d2), 67);
    check("b2b_gap_idle", 32'(b34), 0);
    check("b2b_restart", 32'(b35), 1);
    check("b2b_count", 32'(dones), 2);
    check("b2b_pass", 32'(m_pass), 1);
    check("b2b_table", 32'(m_table), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4, meaning clock cycles each input pattern is held (legal range 2..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request a sweep; sampled only in IDLE.
REQ-005 The block SHALL have port expect_in  input  8  expected truth table, bit i = expected Z for pattern i; captured on accepted start.
REQ-006 The block SHALL have port z_in  input  1  response from the downstream 3-input combinational circuit.
REQ-007 The block SHALL have ports a_out, b_out, c_out  output  1 each  stimulus to the circuit's A2, B2, C2 inputs.
REQ-008 The block SHALL have port busy  output  1  high in DRIVE state.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 The block SHALL have port table_out  output  8  captured Z values, bit i for pattern i.
REQ-011 The block SHALL have port sample_valid  output  1  one-cycle pulse when a Z sample is captured.
REQ-012 The block SHALL have port mismatch_count  output  4  number of captured bits differing from expect_in (0..8).
REQ-013 The block SHALL have port pass  output  1  high when mismatch_count is 0 after a completed sweep.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, DONE.
REQ-015 IDLE->DRIVE SHALL occur on the edge where start=1; on that edge idx<=0, hold_cnt<=0, table_out<=0, mismatch_count<=0, pass<=0, expected<=expect_in.
REQ-016 In DRIVE, {a_out,b_out,c_out} SHALL equal idx[2:0], with a_out the MSB; in IDLE and DONE they SHALL be 000.
REQ-017 hold_cnt SHALL increment each DRIVE cycle; on the cycle where hold_cnt==HOLD_CYCLES-1, z_in SHALL be written to table_out[idx] and sample_valid SHALL be 1.
REQ-018 On a sample with z_in != expected[idx], mismatch_count SHALL increment by 1 on the same edge.
REQ-019 After a sample, if idx<7 then idx<=idx+1 and hold_cnt<=0; if idx==7 then state<=DONE.
REQ-020 Each pattern SHALL be driven for exactly HOLD_CYCLES cycles; sweep length SHALL be 8*HOLD_CYCLES DRIVE cycles; done SHALL be high in the cycle after the last sample.
REQ-021 DONE SHALL last one cycle, assert done=1, set pass<=(mismatch_count==0), then return to IDLE.
REQ-022 start SHALL be ignored in DRIVE and DONE; start held high in IDLE SHALL begin a new sweep on every entry to IDLE.
REQ-023 table_out, mismatch_count and pass SHALL hold their values in IDLE until the next accepted start.
REQ-024 idx SHALL never wrap; no pattern is driven twice in one sweep.

Reset
REQ-025 On rst=1 at a clock edge: state<=IDLE, idx<=0, hold_cnt<=0, a/b/c_out=0, busy=0, done=0, sample_valid=0, table_out=0, mismatch_count=0, pass=0.
REQ-026 rst SHALL take priority over start and over any in-progress sweep; a sweep interrupted by rst SHALL be abandoned, with no done pulse.

Structure
REQ-027 FSM state encoding and the pattern count constant (8) SHALL live in a shared package/include file.
REQ-028 The hold counter SHALL be a sub-module hold_counter (terminal-count output, synchronous clear); the remaining logic is flat.

Verification
REQ-029 With HOLD_CYCLES=4, expect_in=8'b1000_0000, an AND3 downstream, and start pulsed once: done at cycle 33 after the start edge, table_out=8'h80, mismatch_count=0, pass=1.
REQ-030 With an XOR3 downstream and expect_in=8'h96: 8 sample_valid pulses are produced, 4 cycles apart; table_out=8'h96; pass=1.
REQ-031 With an AND3 downstream and expect_in=8'h00: mismatch_count=1 and pass=0 at done.
REQ-032 rst asserted during pattern 3: the next cycle shows all outputs 0 and state IDLE; no done pulse follows.
REQ-033 start pulsed during DRIVE is ignored; start held high continuously produces back-to-back sweeps one IDLE cycle apart.
REQ-034 With HOLD_CYCLES=2: a_out/b_out/c_out step through 000..111, each for 2 cycles, and done arrives 17 cycles after the start edge.
